// File: rtl/seq_divider.sv
// seq_divider: 8-bit by 4-bit sequential shift-subtract restoring divider
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   start - request a division, sampled only in IDLE
//   dn    - unsigned 8-bit dividend, captured when start is accepted
//   dv    - unsigned 4-bit divisor, captured when start is accepted
//   q     - registered quotient, held until the next completion
//   r     - registered remainder, held until the next completion
//   busy  - high in every state other than IDLE
//   done  - one-cycle completion pulse
//   dbz   - divide-by-zero flag, valid with done and held afterwards
module seq_divider (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] dn,
   input  logic [3:0] dv,
   output logic [7:0] q,
   output logic [3:0] r,
   output logic       busy,
   output logic       done,
   output logic       dbz
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state_q, state_d;
   logic [4:0] a_q, a_d;
   logic [7:0] sh_q, sh_d;
   logic [3:0] d_q, d_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] quo_q, quo_d;
   logic [3:0] rem_q, rem_d;
   logic       done_q, done_d;
   logic       dbz_q, dbz_d;
   logic       accept, last, ge;
   logic [5:0] a_sh;
   logic [4:0] t, a_nxt;
   logic [7:0] sh_nxt;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      accept  = (state_q == IDLE) && start;
      last    = (cnt_q == 4'd7);
      state_d = (state_q == IDLE) ? (start ? ((dv == 4'd0) ? DONE : CALC) : IDLE) :
                (state_q == CALC) ? (last ? DONE : CALC) : IDLE;
   end

   always_comb begin
      busy = (state_q != IDLE);
      q    = quo_q;
      r    = rem_q;
      done = done_q;
      dbz  = dbz_q;
   end

   // One restoring step; a_sh[5] only guards the compare, since a kept
   // remainder never exceeds 2*15-1 the subtract result fits in 5 bits.
   always_comb begin
      a_sh   = {a_q, sh_q[7]};
      ge     = a_sh >= {2'b00, d_q};
      t      = a_sh[4:0] - {1'b0, d_q};
      a_nxt  = ge ? t : a_sh[4:0];
      sh_nxt = {sh_q[6:0], ge};
   end

   always_comb begin
      a_d    = a_q;
      sh_d   = sh_q;
      d_d    = d_q;
      cnt_d  = cnt_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      done_d = 1'b0;
      if (accept && (dv != 4'd0)) begin
         a_d   = 5'd0;
         sh_d  = dn;
         d_d   = dv;
         cnt_d = 4'd0;
      end else if (accept) begin
         quo_d  = 8'hFF;
         rem_d  = dn[3:0];
         dbz_d  = 1'b1;
         done_d = 1'b1;
      end
      if (state_q == CALC) begin
         a_d   = a_nxt;
         sh_d  = sh_nxt;
         cnt_d = cnt_q + 4'd1;
         // Publish the result of this final iteration, not the stale registers.
         if (last) begin
            quo_d  = sh_nxt;
            rem_d  = a_nxt[3:0];
            dbz_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         sh_q   <= '0;
         d_q    <= '0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         sh_q   <= sh_d;
         d_q    <= d_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
         done_q <= done_d;
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider
module tb_seq_divider;
   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] dn;
   logic [3:0] dv;
   logic [7:0] q;
   logic [3:0] r;
   logic       busy;
   logic       done;
   logic       dbz;
   int         tests;
   int         fails;

   seq_divider dut (
      .clk(clk), .reset(reset), .start(start), .dn(dn), .dv(dv),
      .q(q), .r(r), .busy(busy), .done(done), .dbz(dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Start one division, then observe n negedges; at = index of first done
   // (sample j follows edge N+j), or -1 when done never rose.
   task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int n,
                         output int at, output int nbusy, output int ndone);
      @(negedge clk);
      dn = a; dv = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      at = -1; nbusy = 0; ndone = 0;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (at < 0) at = j;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b1; dn = 8'd100; dv = 4'd7;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({q, r, busy, done, dbz} !== 15'h0) begin
         fails++;
         $display("FAIL reset: q=%0d r=%0d busy=%b done=%b dbz=%b, required all zero", q, r, busy, done, dbz);
      end
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int at, nb, nd;
      run_op(8'd100, 4'd7, 20, at, nb, nd);
      tests++;
      if (at !== 8 || nd !== 1 || nb !== 9) begin
         fails++;
         $display("FAIL basic_timing: done_at=%0d pulses=%0d busy=%0d, required 8/1/9", at, nd, nb);
      end
      tests++;
      if (q !== 8'd14 || r !== 4'd2 || dbz !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required 14 2 0", q, r, dbz);
      end
   endtask

   task automatic test_values;
      logic [7:0] va [3] = '{8'd255, 8'd200, 8'd5};
      logic [3:0] vb [3] = '{4'd1, 4'd15, 4'd9};
      logic [7:0] eq [3] = '{8'd255, 8'd13, 8'd0};
      logic [3:0] er [3] = '{4'd0, 4'd5, 4'd5};
      int at, nb, nd;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], 12, at, nb, nd);
         tests++;
         if (q !== eq[i] || r !== er[i] || at !== 8) begin
            fails++;
            $display("FAIL values %0d/%0d: q=%0d r=%0d at=%0d, required %0d %0d 8", va[i], vb[i], q, r, at, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_dbz;
      int at, nb, nd;
      run_op(8'd77, 4'd0, 6, at, nb, nd);
      tests++;
      if (at !== 0 || nd !== 1 || nb !== 1) begin
         fails++;
         $display("FAIL dbz_timing: done_at=%0d pulses=%0d busy=%0d, required 0/1/1", at, nd, nb);
      end
      tests++;
      if (q !== 8'hFF || r !== 4'd13 || dbz !== 1'b1) begin
         fails++;
         $display("FAIL dbz_result: q=%0h r=%0d dbz=%b, required ff 13 1", q, r, dbz);
      end
      run_op(8'd100, 4'd7, 12, at, nb, nd);
      tests++;
      if (dbz !== 1'b0 || q !== 8'd14 || r !== 4'd2) begin
         fails++;
         $display("FAIL dbz_clear: dbz=%b q=%0d r=%0d, required 0 14 2", dbz, q, r);
      end
   endtask

   task automatic test_midchange;
      int nd;
      @(negedge clk);
      dn = 8'd100; dv = 4'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      nd = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (done) nd++;
         if (j == 2) begin
            dn = 8'd50; dv = 4'd3; start = 1'b1;
         end
         if (j == 3) start = 1'b0;
      end
      tests++;
      if (q !== 8'd14 || r !== 4'd2 || nd !== 1) begin
         fails++;
         $display("FAIL midchange: q=%0d r=%0d pulses=%0d, required 14 2 1", q, r, nd);
      end
   endtask

   task automatic test_abort;
      int nd, at, nb;
      @(negedge clk);
      dn = 8'd100; dv = 4'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      nd = 0;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         if (done) nd++;
         if (j == 3) reset = 1'b1;
         if (j == 4) begin
            tests++;
            if (q !== 8'd0 || r !== 4'd0 || busy !== 1'b0) begin
               fails++;
               $display("FAIL abort_state: q=%0d r=%0d busy=%b, required 0 0 0", q, r, busy);
            end
            reset = 1'b0;
         end
      end
      tests++;
      if (nd !== 0) begin
         fails++;
         $display("FAIL abort_done: pulses=%0d, required 0", nd);
      end
      run_op(8'd255, 4'd1, 12, at, nb, nd);
      tests++;
      if (q !== 8'd255 || r !== 4'd0 || at !== 8) begin
         fails++;
         $display("FAIL abort_recover: q=%0d r=%0d at=%0d, required 255 0 8", q, r, at);
      end
   endtask

   task automatic test_back_to_back;
      int first, second, nd;
      @(negedge clk);
      dn = 8'd10; dv = 4'd3; start = 1'b1;
      @(posedge clk);
      first = -1; second = -1; nd = 0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (first < 0) first = j;
            else if (second < 0) second = j;
         end
         if (j == 18) start = 1'b0;
      end
      tests++;
      if (first !== 8 || second !== 18 || nd !== 2) begin
         fails++;
         $display("FAIL back_to_back: first=%0d second=%0d pulses=%0d, required 8 18 2", first, second, nd);
      end
      tests++;
      if (q !== 8'd3 || r !== 4'd1) begin
         fails++;
         $display("FAIL back_to_back_result: q=%0d r=%0d, required 3 1", q, r);
      end
   endtask

   task automatic test_sweep;
      int k;
      logic seen, wide;
      logic [7:0] gq;
      logic [3:0] gr;
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            @(negedge clk);
            dn = a[7:0]; dv = b[3:0]; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (!done && k < 12);
            seen = done;
            gq = q; gr = r;
            @(negedge clk);
            wide = done;
            tests++;
            if (!seen || wide || k !== 9 || int'(gq) * b + int'(gr) != a || int'(gr) >= b
                || int'(gq) != a / b) begin
               fails++;
               $display("FAIL sweep %0d/%0d: q=%0d r=%0d seen=%b wide=%b k=%0d, required q=%0d r=%0d k=9",
                        a, b, gq, gr, seen, wide, k, a / b, a % b);
            end
         end
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      reset = 1'b0; start = 1'b0; dn = 8'd0; dv = 4'd0;
      test_reset;
      test_basic;
      test_values;
      test_dbz;
      test_midchange;
      test_abort;
      test_back_to_back;
      test_sweep;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL provide port `clk`, input, 1 bit: rising-edge clock; all state changes on this edge only.
REQ-003 The block SHALL provide port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL provide port `start`, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL provide port `dn`, input, 8 bits: unsigned dividend; captured when `start` is accepted.
REQ-006 The block SHALL provide port `dv`, input, 4 bits: unsigned divisor; captured when `start` is accepted.
REQ-007 The block SHALL provide port `q`, output, 8 bits: registered quotient.
REQ-008 The block SHALL provide port `r`, output, 4 bits: registered remainder.
REQ-009 The block SHALL provide port `busy`, output, 1 bit: high in every state other than IDLE.
REQ-010 The block SHALL provide port `done`, output, 1 bit: registered one-cycle completion pulse.
REQ-011 The block SHALL provide port `dbz`, output, 1 bit: registered divide-by-zero flag; valid while `done`=1 and held afterwards.
REQ-012 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-013 The block SHALL contain an FSM with states IDLE, CALC and DONE, plus a datapath (shift-subtract restoring divider) in one module.
REQ-014 The datapath SHALL hold a 5-bit partial remainder register A, an 8-bit quotient/dividend shift register Q, a 4-bit divisor register D and a 4-bit iteration counter.
REQ-015 In IDLE with `start`=1 at edge N and `dv`!=0: D<=dv, Q<=dn, A<=0, count<=0, next state CALC.
REQ-016 In IDLE with `start`=1 at edge N and `dv`==0: next state DONE at edge N; q<=8'hFF, r<=dn[3:0], dbz<=1 and done<=1 at that same edge.
REQ-017 Each CALC edge SHALL shift {A,Q} left by one and form T = shifted A - {1'b0,D}.
REQ-018 If T is non-negative, the CALC edge SHALL set A<=T and Q[0]<=1; otherwise A keeps the shifted value and Q[0]<=0; count increments.
REQ-019 The CALC state SHALL last exactly 8 edges (N+1..N+8).
REQ-020 At edge N+8 (the final iteration), q<=final Q, r<=final A[3:0], dbz<=0, done<=1, and next state is DONE.
REQ-021 Edge N+8 SHALL use the values produced by that final iteration, not those of the preceding cycle.
REQ-022 Latency: `done` SHALL be high during the cycle after edge N+8 for a valid divisor, and during the cycle after edge N for a zero divisor.
REQ-023 `done` SHALL be high for exactly one cycle.
REQ-024 From DONE, the next edge SHALL clear `done` and return the FSM to IDLE unconditionally; a `start` seen in DONE is ignored.
REQ-025 `start` SHALL be ignored whenever `busy`=1; `dn`/`dv` changes during CALC SHALL NOT affect the result.
REQ-026 A back-to-back `start` held high SHALL be accepted on the first IDLE edge after DONE.
REQ-027 q, r and dbz SHALL hold their last values until the next completion.
REQ-028 Width rule: A is 5 bits because a shifted remainder is at most 2*15-1=29; the final remainder is always < dv and fits in 4 bits.
REQ-029 The quotient SHALL satisfy q*dv + r == dn for all dv!=0, with r < dv.

Reset
REQ-030 On `reset`=1 at any edge: FSM<=IDLE, and q, r, A, Q, D, count <= 0, with busy=0, done=0 and dbz=0.
REQ-031 Reset SHALL take priority over `start` and over any in-progress operation; an aborted division produces no `done` pulse.

Verification
REQ-032 Bench: dn=100, dv=7, start 1 cycle -> done 8 cycles after the start edge, q=14, r=2, dbz=0, busy high 9 cycles.
REQ-033 Bench: dn=255/dv=1 -> q=255, r=0; dn=200/dv=15 -> q=13, r=5; dn=5/dv=9 -> q=0, r=5.
REQ-034 Bench: dn=77, dv=0 -> done the cycle after the start edge, q=8'hFF, r=13, dbz=1; the next valid division clears dbz.
REQ-035 Bench: start 100/7, then at edge N+3 change dn/dv and pulse start -> result still q=14, r=2, with a single done pulse.
REQ-036 Bench: start 100/7, assert reset at edge N+4 -> q=0, r=0, busy=0, no done pulse; a subsequent 255/1 completes normally.
REQ-037 Bench: exhaustive sweep of all 256x15 nonzero operand pairs -> REQ-029 holds for each, and every done pulse is exactly 1 cycle wide.
